uart_top: RTL and testbench

Minimal full-duplex UART core: an 8-bit transmitter started by a one-cycle `go` strobe and an 8-bit receiver that reports the last received byte and a framing-error flag. The frame format is fixed at 8N1, MSB first. The bit period is a parameter in system clocks. It sits between a host-side controller (byte/strobe interface) and the external serial pins.

---
 rtl/uart_top.sv | 168 ++++++++++++++++
 tb/tb_uart_top.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_top.sv
// Minimal full-duplex 8N1 UART, MSB first. TX is started by a one-cycle go strobe;
// RX reports the last received byte and whether its stop bit was missing.
module uart_top #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [7:0] txdata,
    output logic       txbusy,
    output logic       txd,
    input  logic       rxd,
    output logic [7:0] rxdata,
    output logic       frameerror
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    // ---------------------------------------------------------------- transmitter
    tx_state_e       tx_state_q;
    logic [CntW-1:0] tx_cnt_q;
    logic [2:0]      tx_bit_q;
    logic [7:0]      tx_shift_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd        <= 1'b1;
            txbusy     <= 1'b0;
        end else begin
            case (tx_state_q)
                TxIdle: begin
                    if (go) begin
                        tx_shift_q <= txdata;
                        tx_cnt_q   <= '0;
                        txd        <= 1'b0;
                        txbusy     <= 1'b1;
                        tx_state_q <= TxStart;
                    end
                end
                TxStart: begin
                    if (tx_cnt_q == LastCnt) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        txd        <= tx_shift_q[7];
                        tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                        tx_state_q <= TxData;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CntOne;
                    end
                end
                TxData: begin
                    if (tx_cnt_q == LastCnt) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            txd        <= 1'b1;
                            tx_state_q <= TxStop;
                        end else begin
                            txd        <= tx_shift_q[7];
                            tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                            tx_bit_q   <= tx_bit_q + 3'd1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CntOne;
                    end
                end
                TxStop: begin
                    if (tx_cnt_q == LastCnt) begin
                        tx_cnt_q   <= '0;
                        txbusy     <= 1'b0;
                        tx_state_q <= TxIdle;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CntOne;
                    end
                end
                default: tx_state_q <= TxIdle;
            endcase
        end
    end

    // ---------------------------------------------------------------- receiver
    logic [1:0] sync_q;
    logic       rx_prev_q;
    logic       rx_line;
    logic       rx_fall;

    assign rx_line = sync_q[1];
    // Edge- rather than level-triggered so a held break never restarts a frame.
    assign rx_fall = rx_prev_q & ~rx_line;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], rxd};
            rx_prev_q <= rx_line;
        end
    end

    rx_state_e       rx_state_q;
    logic [CntW-1:0] rx_cnt_q;
    logic [2:0]      rx_bit_q;
    logic [7:0]      rx_shift_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rxdata     <= 8'h00;
            frameerror <= 1'b0;
        end else begin
            case (rx_state_q)
                RxIdle: begin
                    if (rx_fall) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RxStart;
                    end
                end
                RxStart: begin
                    if (rx_cnt_q == HalfCnt) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_line ? RxIdle : RxData;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CntOne;
                    end
                end
                RxData: begin
                    if (rx_cnt_q == LastCnt) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_shift_q[6:0], rx_line};
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= RxStop;
                        end else begin
                            rx_bit_q <= rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CntOne;
                    end
                end
                RxStop: begin
                    if (rx_cnt_q == LastCnt) begin
                        rx_cnt_q   <= '0;
                        rxdata     <= rx_shift_q;
                        frameerror <= ~rx_line;
                        rx_state_q <= RxIdle;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CntOne;
                    end
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_top.sv
// Self-checking bench for uart_top: randomized TX/RX frames against a line-level
// model of the 8N1 MSB-first frame format.
module tb_uart_top;

    localparam int N = 4;

    logic       clk;
    logic       rst;
    logic       go;
    logic [7:0] txdata;
    logic       txbusy;
    logic       txd;
    logic       rxd;
    logic [7:0] rxdata;
    logic       frameerror;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_rxdata;
    logic       exp_fe;

    uart_top #(.CLKS_PER_BIT(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .txdata     (txdata),
        .txbusy     (txbusy),
        .txd        (txd),
        .rxd        (rxd),
        .rxdata     (rxdata),
        .frameerror (frameerror)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    // Expected txd c clocks after the accepting edge of a frame carrying b.
    function automatic logic exp_txd(input logic [7:0] b, input int c);
        if (c < N) return 1'b0;
        if (c < 9 * N) return b[7 - (c / N - 1)];
        return 1'b1;
    endfunction

    // Drives one serial frame on rxd; a zero stop bit is held low for extra_low more clocks.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int extra_low);
        @(posedge clk); #1 rxd = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            repeat (N) @(posedge clk);
            #1 rxd = b[i];
        end
        repeat (N) @(posedge clk);
        #1 rxd = stop;
        repeat (N) @(posedge clk);
        if (!stop) repeat (extra_low) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (4 * N) @(posedge clk);
        exp_rxdata = b;
        exp_fe     = ~stop;
    endtask

    task automatic test_reset();
        rst = 1'b1; go = 1'b0; txdata = 8'h00; rxd = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_rxdata = 8'h00; exp_fe = 1'b0;
        @(negedge clk);
        n_cmp++; if (txd !== 1'b1) begin n_err++; $display("FAIL reset_txd got=%b exp=1", txd); end
        n_cmp++; if (txbusy !== 1'b0) begin n_err++; $display("FAIL reset_txbusy got=%b exp=0", txbusy); end
        n_cmp++; if (rxdata !== 8'h00) begin n_err++; $display("FAIL reset_rxdata got=%02h exp=00", rxdata); end
        n_cmp++; if (frameerror !== 1'b0) begin n_err++; $display("FAIL reset_fe got=%b exp=0", frameerror); end
    endtask

    // Single frames; txdata is scrambled after acceptance and a go is pulsed mid-frame.
    task automatic test_tx();
        logic [7:0] b;
        for (int f = 0; f < 4; f++) begin
            b = (f == 0) ? 8'hA5 : 8'($urandom);
            @(negedge clk); go = 1'b1; txdata = b;
            @(posedge clk); #1 go = 1'b0; txdata = ~b;
            for (int c = 0; c <= 10 * N; c++) begin
                @(negedge clk);
                n_cmp++;
                if (txd !== exp_txd(b, c)) begin
                    n_err++;
                    $display("FAIL tx_txd byte=%02h cycle=%0d got=%b exp=%b", b, c, txd, exp_txd(b, c));
                end
                n_cmp++;
                if (txbusy !== 1'(c < 10 * N)) begin
                    n_err++;
                    $display("FAIL tx_busy byte=%02h cycle=%0d got=%b exp=%b", b, c, txbusy, c < 10 * N);
                end
                if (c == 15) begin go = 1'b1; txdata = ~b ^ 8'h3C; end
                else go = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bs [3];
        foreach (bs[i]) bs[i] = 8'($urandom);
        @(negedge clk); go = 1'b1; txdata = bs[0];
        for (int f = 0; f < 3; f++) begin
            @(posedge clk); #1 go = 1'b0; txdata = 8'($urandom);
            for (int c = 0; c <= 10 * N; c++) begin
                @(negedge clk);
                n_cmp++;
                if (txd !== exp_txd(bs[f], c)) begin
                    n_err++;
                    $display("FAIL b2b_txd frame=%0d cycle=%0d got=%b exp=%b", f, c, txd, exp_txd(bs[f], c));
                end
                n_cmp++;
                if (txbusy !== 1'(c < 10 * N)) begin
                    n_err++;
                    $display("FAIL b2b_busy frame=%0d cycle=%0d got=%b exp=%b", f, c, txbusy, c < 10 * N);
                end
                if (c == 10 * N && f < 2) begin go = 1'b1; txdata = bs[f + 1]; end
            end
        end
    endtask

    task automatic test_rx_bad_stop();
        send_frame(8'hB3, 1'b0, 3 * N);
        @(negedge clk);
        n_cmp++; if (rxdata !== exp_rxdata) begin n_err++; $display("FAIL rxbad_data got=%02h exp=%02h", rxdata, exp_rxdata); end
        n_cmp++; if (frameerror !== exp_fe) begin n_err++; $display("FAIL rxbad_fe got=%b exp=%b", frameerror, exp_fe); end
        repeat (12 * N) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (rxdata !== exp_rxdata) begin n_err++; $display("FAIL rxbreak_data got=%02h exp=%02h", rxdata, exp_rxdata); end
        n_cmp++; if (frameerror !== exp_fe) begin n_err++; $display("FAIL rxbreak_fe got=%b exp=%b", frameerror, exp_fe); end
    endtask

    task automatic test_rx_good();
        logic [7:0] b;
        logic       stop;
        for (int f = 0; f < 6; f++) begin
            b    = (f == 0) ? 8'h5A : 8'($urandom);
            stop = (f == 0) ? 1'b1 : 1'($urandom);
            send_frame(b, stop, 2 * N);
            @(negedge clk);
            n_cmp++;
            if (rxdata !== exp_rxdata) begin
                n_err++; $display("FAIL rx_data frame=%0d got=%02h exp=%02h", f, rxdata, exp_rxdata);
            end
            n_cmp++;
            if (frameerror !== exp_fe) begin
                n_err++; $display("FAIL rx_fe frame=%0d got=%b exp=%b", f, frameerror, exp_fe);
            end
        end
    endtask

    task automatic test_glitch();
        @(posedge clk); #1 rxd = 1'b0;
        @(posedge clk); #1 rxd = 1'b1;
        repeat (12 * N) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (rxdata !== exp_rxdata) begin n_err++; $display("FAIL glitch_data got=%02h exp=%02h", rxdata, exp_rxdata); end
        n_cmp++; if (frameerror !== exp_fe) begin n_err++; $display("FAIL glitch_fe got=%b exp=%b", frameerror, exp_fe); end
    endtask

    task automatic test_full_duplex();
        logic [7:0] tb_byte;
        logic [7:0] rb_byte;
        tb_byte = 8'($urandom);
        rb_byte = 8'($urandom);
        fork
            send_frame(rb_byte, 1'b1, 0);
            begin
                @(negedge clk); go = 1'b1; txdata = tb_byte;
                @(posedge clk); #1 go = 1'b0;
                for (int c = 0; c <= 10 * N; c++) begin
                    @(negedge clk);
                    n_cmp++;
                    if (txd !== exp_txd(tb_byte, c)) begin
                        n_err++;
                        $display("FAIL duplex_txd cycle=%0d got=%b exp=%b", c, txd, exp_txd(tb_byte, c));
                    end
                end
            end
        join
        @(negedge clk);
        n_cmp++; if (rxdata !== exp_rxdata) begin n_err++; $display("FAIL duplex_rxdata got=%02h exp=%02h", rxdata, exp_rxdata); end
        n_cmp++; if (frameerror !== exp_fe) begin n_err++; $display("FAIL duplex_fe got=%b exp=%b", frameerror, exp_fe); end
    endtask

    // Reset lands at cycle 15 of a TX frame while an RX frame is also in flight.
    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'($urandom);
        @(negedge clk); go = 1'b1; txdata = b; rxd = 1'b0;
        @(posedge clk); #1 go = 1'b0;
        for (int c = 0; c <= 15; c++) begin
            @(negedge clk);
            if (c >= N) rxd = 1'($urandom);
            if (c == 15) rst = 1'b1;
        end
        @(posedge clk); #1 rst = 1'b0; rxd = 1'b1;
        exp_rxdata = 8'h00; exp_fe = 1'b0;
        @(negedge clk);
        n_cmp++; if (txd !== 1'b1) begin n_err++; $display("FAIL rstmid_txd got=%b exp=1", txd); end
        n_cmp++; if (txbusy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", txbusy); end
        n_cmp++; if (rxdata !== exp_rxdata) begin n_err++; $display("FAIL rstmid_rxdata got=%02h exp=%02h", rxdata, exp_rxdata); end
        repeat (12 * N) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (rxdata !== exp_rxdata) begin n_err++; $display("FAIL rstmid_discard got=%02h exp=%02h", rxdata, exp_rxdata); end
        n_cmp++; if (frameerror !== exp_fe) begin n_err++; $display("FAIL rstmid_fe got=%b exp=%b", frameerror, exp_fe); end
        n_cmp++; if (txd !== 1'b1) begin n_err++; $display("FAIL rstmid_idle_txd got=%b exp=1", txd); end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_back_to_back();
        test_rx_bad_stop();
        test_rx_good();
        test_glitch();
        test_full_duplex();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
